// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port (ALU vs LSU),
// with one registered write stage and a pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [AW-1:0]     lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic [2**AW-1:0]  busy
);

  localparam int NREG = 2**AW;

  logic              ptr_lsu_reg;
  logic              rf_we_reg;
  logic [AW-1:0]     rf_wa_reg;
  logic [XLEN-1:0]   rf_wd_reg;
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;

  logic              contested;
  logic              grant_any;
  logic [AW-1:0]     grant_rd;
  logic [XLEN-1:0]   grant_data;

  assign contested  = alu_valid & lsu_valid;
  assign lsu_ready  = lsu_valid & (~alu_valid | ptr_lsu_reg);
  assign alu_ready  = alu_valid & (~lsu_valid | ~ptr_lsu_reg);
  assign grant_any  = lsu_ready | alu_ready;
  assign grant_rd   = lsu_ready ? lsu_rd : alu_rd;
  assign grant_data = lsu_ready ? lsu_data : alu_data;

  // Pointer names the side that wins the next contested cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_lsu_reg <= LSU_FIRST;
    end else if (contested) begin
      ptr_lsu_reg <= ~ptr_lsu_reg;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_reg <= 1'b0;
      rf_wa_reg <= '0;
      rf_wd_reg <= '0;
    end else begin
      rf_we_reg <= grant_any && (grant_rd != '0);
      if (grant_any) begin
        rf_wa_reg <= grant_rd;
        rf_wd_reg <= grant_data;
      end
    end
  end

  // Per-register scoreboard: a new reservation overrides a simultaneous writeback clear.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_xn
        assign busy_next[gi] = (issue_valid && (issue_rd == AW'(gi))) |
                               (busy_reg[gi] & ~(rf_we_reg && (rf_wa_reg == AW'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rf_we = rf_we_reg;
  assign rf_wa = rf_wa_reg;
  assign rf_wd = rf_wd_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of the writeback arbiter, output stage and scoreboard.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.XLEN(32), .AW(5), .LSU_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Random-phase state
  logic        ptr_m;
  logic        we_m, nwe_m;
  logic [4:0]  wa_m;
  logic [31:0] wd_m;
  logic [31:0] busy_m;
  logic        g_alu, g_lsu;
  logic [31:0] rf_model [32];
  logic [31:0] rf_dut   [32];

  initial begin
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;

    // Reset state
    #12;
    check_val("reset_rf_we", rf_we, 0);
    check_val("reset_rf_wa", rf_wa, 0);
    check_val("reset_rf_wd", rf_wd, 0);
    check_val("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Single source
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    check_val("single_alu_ready", alu_ready, 1);
    check_val("single_lsu_ready", lsu_ready, 0);
    cyc();
    alu_valid = 0;
    check_val("single_rf_we", rf_we, 1);
    check_val("single_rf_wa", rf_wa, 5);
    check_val("single_rf_wd", rf_wd, 32'hDEADBEEF);
    cyc();
    check_val("idle_rf_we", rf_we, 0);

    // Contention: LSU first, then ALU
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3333;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h4444;
    #1;
    check_val("cont0_lsu_ready", lsu_ready, 1);
    check_val("cont0_alu_ready", alu_ready, 0);
    cyc();
    lsu_valid = 0;
    check_val("cont0_rf_wa", rf_wa, 3);
    check_val("cont0_rf_wd", rf_wd, 32'h3333);
    #1;
    check_val("cont1_alu_ready", alu_ready, 1);
    cyc();
    check_val("cont1_rf_wa", rf_wa, 4);
    check_val("cont1_rf_wd", rf_wd, 32'h4444);

    // Continuous contention: pointer now ALU, strict alternation
    lsu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("alt_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
      check_val("alt_lsu_ready", lsu_ready, (i % 2 == 0) ? 0 : 1);
      cyc();
      check_val("alt_rf_wa", rf_wa, (i % 2 == 0) ? 4 : 3);
    end
    alu_valid = 0; lsu_valid = 0;
    cyc();

    // x0 drop
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    #1;
    check_val("x0_lsu_ready", lsu_ready, 1);
    cyc();
    lsu_valid = 0;
    check_val("x0_rf_we", rf_we, 0);
    check_val("x0_busy", busy, 0);

    // Scoreboard: set, then clear on writeback
    issue_valid = 1; issue_rd = 7;
    cyc();
    issue_valid = 0;
    check_val("sb_set7", busy, 32'h80);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    cyc();
    alu_valid = 0;
    check_val("sb_wb_rf_we", rf_we, 1);
    check_val("sb_still_busy", busy, 32'h80);
    cyc();
    check_val("sb_cleared", busy, 0);
    issue_valid = 1; issue_rd = 0;
    cyc();
    issue_valid = 0;
    check_val("sb_x0_never_set", busy, 0);

    // Scoreboard: set wins over same-edge clear
    issue_valid = 1; issue_rd = 7;
    cyc();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    cyc();
    alu_valid = 0;
    issue_valid = 1; issue_rd = 7;
    cyc();
    issue_valid = 0;
    check_val("sb_set_wins", busy, 32'h80);

    // Asynchronous reset mid-transfer
    alu_valid = 1; alu_rd = 9; alu_data = 32'h9999;
    cyc();
    alu_valid = 0;
    check_val("mid_rf_we_before", rf_we, 1);
    rst = 1'b0;
    #1;
    check_val("async_rf_we", rf_we, 0);
    check_val("async_busy", busy, 0);
    check_val("async_rf_wa", rf_wa, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0A0;
    lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hB1B1;
    #1;
    check_val("post_reset_lsu_first", lsu_ready, 1);
    cyc();
    lsu_valid = 0;
    check_val("post_reset_rf_wa", rf_wa, 11);
    check_val("post_reset_rf_wd", rf_wd, 32'hB1B1);
    cyc();
    alu_valid = 0;
    check_val("post_reset_alu_wa", rf_wa, 10);
    check_val("post_reset_alu_wd", rf_wd, 32'hA0A0);
    cyc();

    // Random traffic against a reference model
    ptr_m = 1'b0;     // one contested cycle since reset flipped it to ALU
    we_m = 0; wa_m = 0; wd_m = 0; busy_m = 0;
    for (int r = 0; r < 32; r++) begin
      rf_model[r] = 0;
      rf_dut[r] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      if (!alu_valid && ($urandom_range(1) == 1)) begin
        alu_valid = 1; alu_rd = 5'($urandom_range(31)); alu_data = $urandom;
      end
      if (!lsu_valid && ($urandom_range(1) == 1)) begin
        lsu_valid = 1; lsu_rd = 5'($urandom_range(31)); lsu_data = $urandom;
      end
      issue_valid = ($urandom_range(2) == 0);
      issue_rd = 5'($urandom_range(31));
      #1;
      g_lsu = lsu_valid && (!alu_valid || ptr_m);
      g_alu = alu_valid && (!lsu_valid || !ptr_m);
      check_val("rnd_alu_ready", alu_ready, g_alu);
      check_val("rnd_lsu_ready", lsu_ready, g_lsu);
      busy_m = busy_m & ~((we_m ? 32'h1 : 32'h0) << wa_m);
      if (issue_valid && issue_rd != 0) busy_m = busy_m | (32'h1 << issue_rd);
      if (alu_valid && lsu_valid) ptr_m = !ptr_m;
      nwe_m = 0;
      if (g_lsu) begin
        nwe_m = (lsu_rd != 0); wa_m = lsu_rd; wd_m = lsu_data;
      end else if (g_alu) begin
        nwe_m = (alu_rd != 0); wa_m = alu_rd; wd_m = alu_data;
      end
      we_m = nwe_m;
      cyc();
      if (g_alu) alu_valid = 0;
      if (g_lsu) lsu_valid = 0;
      check_val("rnd_rf_we", rf_we, we_m);
      if (we_m) begin
        check_val("rnd_rf_wa", rf_wa, wa_m);
        check_val("rnd_rf_wd", rf_wd, wd_m);
        rf_model[wa_m] = wd_m;
      end
      if (rf_we) rf_dut[rf_wa] = rf_wd;
      check_val("rnd_busy", busy, busy_m);
    end
    for (int r = 0; r < 32; r++) begin
      check_val($sformatf("rf_x%0d", r), rf_dut[r], rf_model[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
